// File: rtl/player_input_hub_if.sv
// Bus bundle between the board GPIO / game-state logic and player_input_hub.
// The hub sits on the slave side; the board/top side drives through master.
interface player_input_hub_if #(
  parameter int unsigned NUM_PLAYERS = 2
) ();
  logic [5*NUM_PLAYERS-1:0] i_btn;
  logic [1:0]               i_game_state;
  logic [5*NUM_PLAYERS-1:0] o_btn;
  logic [3*NUM_PLAYERS-1:0] o_dir;
  logic [NUM_PLAYERS-1:0]   o_fire;
  logic [NUM_PLAYERS-1:0]   o_joined;
  logic                     o_start;
  logic [5*NUM_PLAYERS-1:0] o_led;

  modport master (
    output i_btn, i_game_state,
    input  o_btn, o_dir, o_fire, o_joined, o_start, o_led
  );

  modport slave (
    input  i_btn, i_game_state,
    output o_btn, o_dir, o_fire, o_joined, o_start, o_led
  );
endinterface

// File: rtl/player_input_hub.sv
// N-player input front end: sync + debounce, direction encode, fire pulses, lobby join/start, LEDs.
// Optional HUB_AUTOFIRE_EN adds per-player auto-repeat of fire while held outside the lobby.
module player_input_hub #(
  parameter int unsigned NUM_PLAYERS     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_CYCLES   = 6250000,
  parameter logic [1:0]  LOBBY_STATE     = 2'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  player_input_hub_if.slave   bus
);

  localparam int unsigned NB  = 5 * NUM_PLAYERS;
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("player_input_hub: parameter out of range");
  end

  typedef enum logic {IDLE = 1'b0, JOINED = 1'b1} join_state_t;

  logic [NB-1:0]            sync1, sync2, stable, btn_q, led_q;
  logic [DBW-1:0]           db_cnt [NB];
  logic [3*NUM_PLAYERS-1:0] dir_q;
  join_state_t              join_state [NUM_PLAYERS];
  join_state_t              join_nxt   [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]   fire_rise, fire_edge_q, fire_q, rpt_hit, joined_vec;
  logic [1:0]               gs_q;
  logic                     in_lobby, lobby_entry, joined_all, all_q, start_q;

  // Axis pairs cancel, then up > down > left > right; b = {fire,right,left,down,up}
  function automatic logic [2:0] encode_dir(input logic [4:0] b);
    logic [2:0] d;
    if (b[0] && !b[1])      d = 3'b100;
    else if (b[1] && !b[0]) d = 3'b101;
    else if (b[2] && !b[3]) d = 3'b110;
    else if (b[3] && !b[2]) d = 3'b111;
    else                    d = 3'b000;
    return d;
  endfunction

  // Fire edges and per-player join next-state; a lobby re-entry cycle drops any fire pulse
  always_comb begin
    in_lobby    = (bus.i_game_state == LOBBY_STATE);
    lobby_entry = in_lobby && (gs_q != LOBBY_STATE);
    joined_all  = 1'b1;
    fire_rise   = '0;
    joined_vec  = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      fire_rise[p]  = stable[5*p+4] & ~btn_q[5*p+4];
      joined_vec[p] = (join_state[p] == JOINED);
      joined_all    = joined_all & joined_vec[p];
      join_nxt[p]   = join_state[p];
      case (join_state[p])
        IDLE:    if (fire_edge_q[p] && in_lobby && !lobby_entry) join_nxt[p] = JOINED;
        JOINED:  if (lobby_entry) join_nxt[p] = IDLE;
        default: join_nxt[p] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      stable      <= '0;
      btn_q       <= '0;
      led_q       <= '0;
      dir_q       <= '0;
      gs_q        <= '0;
      fire_edge_q <= '0;
      fire_q      <= '0;
      all_q       <= 1'b0;
      start_q     <= 1'b0;
      for (int b = 0; b < NB; b++) db_cnt[b] <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) join_state[p] <= IDLE;
    end else begin
      sync1 <= bus.i_btn;
      sync2 <= sync1;
      // Counter only runs while synced and stable disagree, so it tops out at DB_LAST
      for (int b = 0; b < NB; b++) begin
        if (sync2[b] == stable[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          stable[b] <= ~stable[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + DBW'(1);
        end
      end
      btn_q       <= stable;
      gs_q        <= bus.i_game_state;
      fire_edge_q <= fire_rise;
      fire_q      <= fire_rise | rpt_hit;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        join_state[p]  <= join_nxt[p];
        dir_q[3*p +: 3] <= encode_dir(stable[5*p +: 5]);
        led_q[5*p +: 5] <= (in_lobby && join_nxt[p] == JOINED) ? 5'h1f : stable[5*p +: 5];
      end
      all_q   <= joined_all;
      start_q <= joined_all & ~all_q & in_lobby;
    end
  end

`ifdef HUB_AUTOFIRE_EN
  localparam int unsigned RPW = $clog2(REPEAT_CYCLES);
  localparam logic [RPW-1:0] RPT_LAST = RPW'(REPEAT_CYCLES - 1);

  logic [RPW-1:0]         rpt_cnt [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] rpt_held;

  always_comb begin
    rpt_held = '0;
    rpt_hit  = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      rpt_held[p] = stable[5*p+4] & btn_q[5*p+4] & ~in_lobby;
      rpt_hit[p]  = rpt_held[p] && (rpt_cnt[p] == RPT_LAST);
    end
  end

  // Counts held cycles since the edge pulse; wraps on each repeat pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PLAYERS; p++) rpt_cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (!rpt_held[p] || rpt_hit[p]) rpt_cnt[p] <= '0;
        else                            rpt_cnt[p] <= rpt_cnt[p] + RPW'(1);
      end
    end
  end
`else
  assign rpt_hit = '0;
`endif

  assign bus.o_btn    = btn_q;
  assign bus.o_dir    = dir_q;
  assign bus.o_fire   = fire_q;
  assign bus.o_joined = joined_vec;
  assign bus.o_start  = start_q;
  assign bus.o_led    = led_q;

endmodule

// File: tb/tb_player_input_hub.sv
// Randomised and directed bench for player_input_hub against a window-based reference model.
module tb_player_input_hub;
  localparam int unsigned NP = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned R  = 8;
  localparam int unsigned NB = 5 * NP;
  localparam int unsigned OW = 2 * NB + 3 * NP + 2 * NP + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;

  player_input_hub_if #(.NUM_PLAYERS(NP)) bus ();

  player_input_hub #(
    .NUM_PLAYERS(NP), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R), .LOBBY_STATE(2'd0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [NB-1:0]   m_samp [0:D+1];
  logic [NB-1:0]   m_stable = '0, m_btn = '0, m_led = '0;
  logic [3*NP-1:0] m_dir = '0;
  logic [NP-1:0]   m_edge = '0, m_fire = '0, m_joined = '0, m_jprev = '0;
  logic            m_start = 1'b0;
  logic [1:0]      m_gs_prev = '0;
  int              m_hc [NP];

  logic [OW-1:0] dut_out, mdl_out;
  assign dut_out = {bus.o_btn, bus.o_dir, bus.o_fire, bus.o_joined, bus.o_start, bus.o_led};
  assign mdl_out = {m_btn, m_dir, m_fire, m_joined, m_start, m_led};

  function automatic logic [2:0] ref_dir(input logic [4:0] b);
    logic [1:0] v, h;
    v = {b[1], b[0]};
    h = {b[3], b[2]};
    case (v)
      2'b01:   return 3'b100;
      2'b10:   return 3'b101;
      default: case (h)
                 2'b01:   return 3'b110;
                 2'b10:   return 3'b111;
                 default: return 3'b000;
               endcase
    endcase
  endfunction

  // A bit is accepted once the last D synchronised samples all disagree with the accepted value
  always @(posedge clk or negedge rst_n) begin : model
    logic [NB-1:0] old_btn;
    logic [NP-1:0] old_edge, old_joined;
    logic lobby, entry, held, run;
    if (!rst_n) begin
      for (int k = 0; k <= D + 1; k++) m_samp[k] = '0;
      m_stable = '0; m_btn = '0; m_led = '0; m_dir = '0;
      m_edge = '0; m_fire = '0; m_joined = '0; m_jprev = '0;
      m_start = 1'b0; m_gs_prev = '0;
      for (int p = 0; p < NP; p++) m_hc[p] = 0;
    end else begin
      for (int k = D + 1; k > 0; k--) m_samp[k] = m_samp[k-1];
      m_samp[0] = bus.i_btn;
      old_btn = m_btn;
      m_btn   = m_stable;
      for (int b = 0; b < NB; b++) begin
        run = 1'b1;
        for (int k = 2; k <= D + 1; k++) if (m_samp[k][b] == m_stable[b]) run = 1'b0;
        if (run) m_stable[b] = ~m_stable[b];
      end
      lobby = (bus.i_game_state == 2'd0);
      entry = lobby && (m_gs_prev != 2'd0);
      m_gs_prev  = bus.i_game_state;
      old_edge   = m_edge;
      old_joined = m_joined;
      for (int p = 0; p < NP; p++) begin
        m_edge[p] = m_btn[5*p+4] & ~old_btn[5*p+4];
        if (entry) m_joined[p] = 1'b0;
        else if (old_edge[p] && lobby) m_joined[p] = 1'b1;
`ifdef HUB_AUTOFIRE_EN
        held = m_btn[5*p+4] && old_btn[5*p+4] && !lobby;
        m_hc[p] = held ? m_hc[p] + 1 : 0;
        m_fire[p] = m_edge[p] | (held && (m_hc[p] % R == 0));
`else
        held = 1'b0;
        m_fire[p] = m_edge[p];
`endif
        m_led[5*p +: 5] = (lobby && m_joined[p]) ? 5'h1f : m_btn[5*p +: 5];
        m_dir[3*p +: 3] = ref_dir(m_btn[5*p +: 5]);
      end
      m_start = lobby && (&old_joined) && !(&m_jprev);
      m_jprev = old_joined;
    end
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (dut_out !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", dut_out); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (dut_out !== '0) begin errors++; $display("FAIL reset_idle got %h want 0", dut_out); end
    end
  endtask

  task automatic test_debounce_step();
    bus.i_btn = 10'b00000_00001;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus.o_btn[0] !== 1'(k >= 6)) begin
        errors++; $display("FAIL step_latency k=%0d got %b want %b", k, bus.o_btn[0], k >= 6);
      end
      checks++;
      if (dut_out !== mdl_out) begin errors++; $display("FAIL step_model got %h want %h", dut_out, mdl_out); end
    end
    checks++;
    if (bus.o_dir[2:0] !== 3'b100) begin errors++; $display("FAIL step_dir got %b want 100", bus.o_dir[2:0]); end
  endtask

  task automatic test_glitch();
    bus.i_btn[9] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 2) bus.i_btn[9] = 1'b0;
      checks++;
      if (bus.o_btn[9] !== 1'b0 || bus.o_fire[1] !== 1'b0) begin
        errors++; $display("FAIL glitch k=%0d got btn=%b fire=%b want 0 0", k, bus.o_btn[9], bus.o_fire[1]);
      end
      checks++;
      if (dut_out !== mdl_out) begin errors++; $display("FAIL glitch_model got %h want %h", dut_out, mdl_out); end
    end
  endtask

  task automatic test_direction();
    logic [4:0] pat [6];
    logic [2:0] exp [6];
    pat = '{5'b01011, 5'b01111, 5'b00110, 5'b01100, 5'b01010, 5'b01000};
    exp = '{3'b111,   3'b000,   3'b101,   3'b000,   3'b101,   3'b111};
    for (int i = 0; i < 6; i++) begin
      bus.i_btn[4:0] = pat[i];
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        checks++;
        if (dut_out !== mdl_out) begin errors++; $display("FAIL dir_model got %h want %h", dut_out, mdl_out); end
      end
      checks++;
      if (bus.o_dir[2:0] !== exp[i]) begin
        errors++; $display("FAIL dir_pat%0d got %b want %b", i, bus.o_dir[2:0], exp[i]);
      end
    end
  endtask

  task automatic test_lobby();
    int starts;
    bus.i_btn = '0;
    bus.i_game_state = 2'd0;
    repeat (10) @(negedge clk);
    starts = 0;
    bus.i_btn[4] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.o_start) starts++;
      checks++;
      if (dut_out !== mdl_out) begin errors++; $display("FAIL lobby_model got %h want %h", dut_out, mdl_out); end
    end
    checks++;
    if (bus.o_joined !== 2'b01) begin errors++; $display("FAIL lobby_join1 got %b want 01", bus.o_joined); end
    checks++;
    if (bus.o_led[4:0] !== 5'h1f) begin errors++; $display("FAIL lobby_led got %h want 1f", bus.o_led[4:0]); end
    bus.i_btn[9] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.o_start) starts++;
      checks++;
      if (dut_out !== mdl_out) begin errors++; $display("FAIL lobby_model got %h want %h", dut_out, mdl_out); end
    end
    checks++;
    if (bus.o_joined !== 2'b11) begin errors++; $display("FAIL lobby_join2 got %b want 11", bus.o_joined); end
    checks++;
    if (starts !== 1) begin errors++; $display("FAIL lobby_start_count got %0d want 1", starts); end
    bus.i_game_state = 2'd1;
    starts = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 5) bus.i_game_state = 2'd0;
      if (bus.o_start) starts++;
      checks++;
      if (dut_out !== mdl_out) begin errors++; $display("FAIL round_model got %h want %h", dut_out, mdl_out); end
    end
    checks++;
    if (bus.o_joined !== 2'b00) begin errors++; $display("FAIL round_clear got %b want 00", bus.o_joined); end
    checks++;
    if (starts !== 0) begin errors++; $display("FAIL round_start got %0d want 0", starts); end
    bus.i_btn = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.i_game_state = 2'd0;
    bus.i_btn[4] = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (bus.o_joined !== 2'b01) begin errors++; $display("FAIL rst_pre_join got %b want 01", bus.o_joined); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_out !== '0) begin errors++; $display("FAIL rst_mid_outputs got %h want 0", dut_out); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus.o_btn[4] !== 1'(k >= 6)) begin
        errors++; $display("FAIL rst_reaccept k=%0d got %b want %b", k, bus.o_btn[4], k >= 6);
      end
      checks++;
      if (dut_out !== mdl_out) begin errors++; $display("FAIL rst_model got %h want %h", dut_out, mdl_out); end
    end
    bus.i_btn = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_autofire();
    bit found;
    logic expv;
    bus.i_game_state = 2'd1;
    repeat (3) @(negedge clk);
    bus.i_btn[4] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (bus.o_fire[0]) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL auto_first_pulse got none want pulse within 20 cycles"); end
    for (int off = 1; off <= 30; off++) begin
      @(negedge clk);
`ifdef HUB_AUTOFIRE_EN
      expv = 1'(off % R == 0);
`else
      expv = 1'b0;
`endif
      checks++;
      if (bus.o_fire[0] !== expv) begin
        errors++; $display("FAIL auto_pulse off=%0d got %b want %b", off, bus.o_fire[0], expv);
      end
      checks++;
      if (dut_out !== mdl_out) begin errors++; $display("FAIL auto_model got %h want %h", dut_out, mdl_out); end
    end
    bus.i_btn = '0;
    repeat (8) @(negedge clk);
    bus.i_game_state = 2'd0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    int p;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      checks++;
      if (dut_out !== mdl_out) begin
        errors++; $display("FAIL random_model k=%0d got %h want %h", k, dut_out, mdl_out);
      end
      if ($urandom_range(0, 4) == 0) begin
        p = int'($urandom_range(0, NP - 1));
        bus.i_btn[5*p +: 5] = 5'($urandom);
      end
      if ($urandom_range(0, 49) == 0)
        bus.i_game_state = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    end
  endtask

  initial begin
    bus.i_btn = '0;
    bus.i_game_state = 2'd0;
    test_reset();
    test_debounce_step();
    test_glitch();
    test_direction();
    test_lobby();
    test_reset_mid();
    test_autofire();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
